wdt_controller: RTL and testbench

Watchdog timer peripheral that schedules system resets through the reset controller. It sits on the peripheral bus and counts down from a programmed timeout. If software fails to kick it in time, it drives a fixed-length high pulse on `wdt_rst`, which is wired to the reset controller's `rst_i`. An optional warn mode raises `irq` one full timeout period before the reset.

---
 rtl/wdt_controller.sv | 206 ++++++++++++++++++++
 tb/tb_wdt_controller.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wdt_controller.sv
// Watchdog timer peripheral: bus-programmable countdown with optional warn interrupt,
// driving a fixed-length reset request pulse toward the reset controller.
module wdt_controller #(
   parameter int unsigned BUS_WIDTH     = 32,
   parameter int unsigned BUS_ACC_WIDTH = 2,
   parameter int unsigned CNT_WIDTH     = 32,
   parameter logic [7:0]  KICK_KEY      = 8'hA5,
   parameter int unsigned RST_PULSE     = 4
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [3:0]               addr,
   input  logic                     w_rb,
   input  logic [BUS_ACC_WIDTH-1:0] acc,
   output logic [BUS_WIDTH-1:0]     rdata,
   input  logic [BUS_WIDTH-1:0]     wdata,
   input  logic                     req,
   output logic                     resp,
   output logic                     fault,
   output logic                     irq,
   output logic                     wdt_rst
);

   // acc encodes log2 of the access size in bytes
   localparam logic [BUS_ACC_WIDTH-1:0] ACC_1B = BUS_ACC_WIDTH'(0);
   localparam logic [BUS_ACC_WIDTH-1:0] ACC_4B = BUS_ACC_WIDTH'(2);
   localparam int unsigned BW = $clog2(RST_PULSE + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_WARN = 2'd2,
      S_BITE = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   count_q, count_d;
   logic [CNT_WIDTH-1:0]   load_q, load_d;
   logic                   en_q, en_d, warn_q, warn_d, lock_q, lock_d, flag_q, flag_d;
   logic                   irq_q, irq_d, wdt_rst_q, wdt_rst_d, resp_q;
   logic [BW-1:0]          bite_cnt_q, bite_cnt_d;
   logic [BUS_WIDTH-1:0]   rdata_q, rdata_d, rd_val;
   logic                   invld, valid, wr_ctrl, wr_load, wr_kick, kick_good, ctrl_ok;

   // Address/size decode and fault qualification
   always_comb begin
      invld = 1'b0;
      case (addr)
         4'h0:    invld = (acc != ACC_1B);
         4'h4:    invld = (acc != ACC_4B);
         4'h8:    invld = (acc != ACC_1B) | ~w_rb;
         4'hC:    invld = (acc != ACC_4B) | w_rb;
         default: invld = 1'b1;
      endcase
   end

   assign fault     = req & invld;
   assign valid     = req & ~invld;
   assign wr_ctrl   = valid & w_rb & (addr == 4'h0);
   assign wr_load   = valid & w_rb & (addr == 4'h4);
   assign wr_kick   = valid & w_rb & (addr == 4'h8);
   assign kick_good = wr_kick & (wdata[7:0] == KICK_KEY);
   assign ctrl_ok   = wr_ctrl & ~lock_q;

   // Register writes and watchdog state machine next-state
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      load_d     = load_q;
      en_d       = en_q;
      warn_d     = warn_q;
      lock_d     = lock_q;
      flag_d     = flag_q;
      irq_d      = irq_q;
      wdt_rst_d  = 1'b0;
      bite_cnt_d = bite_cnt_q;

      if (ctrl_ok) begin
         en_d   = wdata[0];
         warn_d = wdata[1];
         lock_d = wdata[2];
      end else begin
         en_d   = en_q;
         warn_d = warn_q;
         lock_d = lock_q;
      end

      if (wr_ctrl && wdata[3]) begin
         flag_d = 1'b0;
      end else begin
         flag_d = flag_q;
      end

      if (wr_load && !lock_q) begin
         load_d = wdata[CNT_WIDTH-1:0];
      end else begin
         load_d = load_q;
      end

      case (state_q)
         S_IDLE: begin
            if (ctrl_ok && !en_q && wdata[0]) begin
               state_d = S_RUN;
               count_d = load_q;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN, S_WARN: begin
            // Kick and disable take precedence over a same-edge expiry
            if (kick_good) begin
               count_d = load_q;
               irq_d   = 1'b0;
               state_d = S_RUN;
            end else if (wr_kick) begin
               state_d    = S_BITE;
               irq_d      = 1'b0;
               bite_cnt_d = '0;
            end else if (ctrl_ok && !wdata[0]) begin
               state_d = S_IDLE;
               irq_d   = 1'b0;
            end else if (count_q == '0) begin
               if (state_q == S_RUN && warn_q) begin
                  count_d = load_q;
                  irq_d   = 1'b1;
                  state_d = S_WARN;
               end else begin
                  state_d    = S_BITE;
                  irq_d      = 1'b0;
                  bite_cnt_d = '0;
               end
            end else begin
               count_d = count_q - CNT_WIDTH'(1);
            end
         end
         S_BITE: begin
            irq_d = 1'b0;
            if (bite_cnt_q == BW'(RST_PULSE)) begin
               state_d   = S_IDLE;
               en_d      = 1'b0;
               wdt_rst_d = 1'b0;
            end else begin
               wdt_rst_d  = 1'b1;
               flag_d     = 1'b1;
               bite_cnt_d = bite_cnt_q + BW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Read mux reflects register contents after the access edge
   always_comb begin
      rd_val = '0;
      case (addr)
         4'h0:    rd_val[3:0] = {flag_d, lock_d, warn_d, en_d};
         4'h4:    rd_val[CNT_WIDTH-1:0] = load_d;
         4'hC:    rd_val[CNT_WIDTH-1:0] = count_d;
         default: rd_val = '0;
      endcase
      if (valid && !w_rb) begin
         rdata_d = rd_val;
      end else begin
         rdata_d = rdata_q;
      end
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         count_q    <= '0;
         load_q     <= {CNT_WIDTH{1'b1}};
         en_q       <= 1'b0;
         warn_q     <= 1'b0;
         lock_q     <= 1'b0;
         flag_q     <= 1'b0;
         irq_q      <= 1'b0;
         wdt_rst_q  <= 1'b0;
         bite_cnt_q <= '0;
         resp_q     <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         load_q     <= load_d;
         en_q       <= en_d;
         warn_q     <= warn_d;
         lock_q     <= lock_d;
         flag_q     <= flag_d;
         irq_q      <= irq_d;
         wdt_rst_q  <= wdt_rst_d;
         bite_cnt_q <= bite_cnt_d;
         resp_q     <= valid;
         rdata_q    <= rdata_d;
      end
   end

   assign rdata   = rdata_q;
   assign resp    = resp_q;
   assign irq     = irq_q;
   assign wdt_rst = wdt_rst_q;

endmodule

// File: tb/tb_wdt_controller.sv
// Directed self-checking bench for wdt_controller: register access, timeout,
// warn, kick, lock, fault and reset scenarios with hand-computed expectations.
module tb_wdt_controller;

   localparam logic [1:0] A1 = 2'd0;
   localparam logic [1:0] A4 = 2'd2;

   logic        clk = 1'b0;
   logic        rstn;
   logic [3:0]  addr;
   logic        w_rb;
   logic [1:0]  acc;
   logic [31:0] rdata;
   logic [31:0] wdata;
   logic        req;
   logic        resp;
   logic        fault;
   logic        irq;
   logic        wdt_rst;

   int          total = 0;
   int          bad   = 0;
   logic        flt_s, rsp_s;
   logic [31:0] rd_s;

   wdt_controller dut (
      .clk     (clk),
      .rstn    (rstn),
      .addr    (addr),
      .w_rb    (w_rb),
      .acc     (acc),
      .rdata   (rdata),
      .wdata   (wdata),
      .req     (req),
      .resp    (resp),
      .fault   (fault),
      .irq     (irq),
      .wdt_rst (wdt_rst)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One bus access occupying exactly one clock edge
   task automatic bus(input logic w, input logic [3:0] a, input logic [1:0] sz, input logic [31:0] d);
      req = 1'b1; w_rb = w; addr = a; acc = sz; wdata = d;
      #1 flt_s = fault;
      @(posedge clk);
      #1;
      req = 1'b0; w_rb = 1'b0; addr = 4'h0; acc = 2'd0; wdata = 32'd0;
      rsp_s = resp;
      rd_s  = rdata;
   endtask

   task automatic wr(input logic [3:0] a, input logic [1:0] sz, input logic [31:0] d, input string tag);
      bus(1'b1, a, sz, d);
      check_val({tag, "_rsp"}, {31'd0, rsp_s}, 32'd1);
   endtask

   task automatic rd(input logic [3:0] a, input logic [1:0] sz, input logic [31:0] exp, input string tag);
      bus(1'b0, a, sz, 32'd0);
      check_val({tag, "_rsp"}, {31'd0, rsp_s}, 32'd1);
      check_val(tag, rd_s, exp);
   endtask

   task automatic fbus(input logic w, input logic [3:0] a, input logic [1:0] sz, input logic [31:0] d, input string tag);
      bus(w, a, sz, d);
      check_val({tag, "_flt"}, {31'd0, flt_s}, 32'd1);
      check_val({tag, "_rsp"}, {31'd0, rsp_s}, 32'd0);
   endtask

   initial begin
      rstn = 1'b0; req = 1'b0; w_rb = 1'b0; addr = 4'h0; acc = 2'd0; wdata = 32'd0;
      ticks(3);
      check_val("rst_irq", {31'd0, irq}, 32'd0);
      check_val("rst_wdt", {31'd0, wdt_rst}, 32'd0);
      check_val("rst_resp", {31'd0, resp}, 32'd0);
      check_val("rst_rdata", rdata, 32'd0);
      rstn = 1'b1;
      rd(4'h0, A1, 32'h0, "rst_ctrl");
      rd(4'h4, A4, 32'hFFFF_FFFF, "rst_load");
      rd(4'hC, A4, 32'h0, "rst_count");

      // Plain timeout: enable at edge R, expiry R+11, pulse R+12..R+15
      wr(4'h4, A4, 32'd10, "t2_load");
      wr(4'h0, A1, 32'h1, "t2_en");
      ticks(2);
      rd(4'hC, A4, 32'd7, "t2_cnt");
      ticks(8);
      check_val("t2_pre", {31'd0, wdt_rst}, 32'd0);
      ticks(1);
      check_val("t2_rise", {31'd0, wdt_rst}, 32'd1);
      rd(4'h0, A1, 32'h9, "t2_ctrl_bite");
      check_val("t2_hi2", {31'd0, wdt_rst}, 32'd1);
      ticks(2);
      check_val("t2_hi4", {31'd0, wdt_rst}, 32'd1);
      ticks(1);
      check_val("t2_fall", {31'd0, wdt_rst}, 32'd0);
      rd(4'h0, A1, 32'h8, "t2_ctrl_after");
      check_val("t2_irq", {31'd0, irq}, 32'd0);
      wr(4'h0, A1, 32'h8, "t2_w1c");
      rd(4'h0, A1, 32'h0, "t2_clr");

      // Warn mode with periodic kicks, then starvation
      wr(4'h0, A1, 32'h3, "t3_en");
      for (int i = 0; i < 12; i++) begin
         ticks(7);
         wr(4'h8, A1, 32'hA5, "t3_kick");
         check_val("t3_noirq", {31'd0, irq}, 32'd0);
      end
      ticks(10);
      check_val("t3_irq_pre", {31'd0, irq}, 32'd0);
      ticks(1);
      check_val("t3_irq", {31'd0, irq}, 32'd1);
      check_val("t3_wdt_lo", {31'd0, wdt_rst}, 32'd0);
      ticks(11);
      check_val("t3_wdt_pre", {31'd0, wdt_rst}, 32'd0);
      ticks(1);
      check_val("t3_wdt", {31'd0, wdt_rst}, 32'd1);
      check_val("t3_irq_clr", {31'd0, irq}, 32'd0);
      ticks(4);
      check_val("t3_wdt_fall", {31'd0, wdt_rst}, 32'd0);
      rd(4'h0, A1, 32'hA, "t3_ctrl");
      wr(4'h0, A1, 32'h8, "t3_clr");

      // Kick during warn returns to RUN; disable coincident with expiry wins
      wr(4'h0, A1, 32'h3, "t3b_en");
      ticks(10);
      check_val("t3b_irq_pre", {31'd0, irq}, 32'd0);
      ticks(1);
      check_val("t3b_irq", {31'd0, irq}, 32'd1);
      wr(4'h8, A1, 32'hA5, "t3b_kick");
      check_val("t3b_irq_clr", {31'd0, irq}, 32'd0);
      rd(4'hC, A4, 32'd9, "t3b_cnt");
      ticks(9);
      check_val("t3b_irq_run", {31'd0, irq}, 32'd0);
      check_val("t3b_wdt_run", {31'd0, wdt_rst}, 32'd0);
      wr(4'h0, A1, 32'h0, "t3b_dis");
      check_val("t3b_dis_irq", {31'd0, irq}, 32'd0);
      rd(4'h0, A1, 32'h0, "t3b_ctrl");
      ticks(15);
      check_val("t3b_idle_wdt", {31'd0, wdt_rst}, 32'd0);
      check_val("t3b_idle_irq", {31'd0, irq}, 32'd0);
      rd(4'hC, A4, 32'd0, "t3b_hold");

      // Wrong kick key bites immediately without fault
      wr(4'h0, A1, 32'h1, "t4_en");
      ticks(2);
      bus(1'b1, 4'h8, A1, 32'h3C);
      check_val("t4_bad_flt", {31'd0, flt_s}, 32'd0);
      check_val("t4_bad_rsp", {31'd0, rsp_s}, 32'd1);
      check_val("t4_wdt_lo", {31'd0, wdt_rst}, 32'd0);
      ticks(1);
      check_val("t4_wdt_rise", {31'd0, wdt_rst}, 32'd1);
      ticks(3);
      check_val("t4_wdt_hi", {31'd0, wdt_rst}, 32'd1);
      ticks(1);
      check_val("t4_wdt_fall", {31'd0, wdt_rst}, 32'd0);
      rd(4'h0, A1, 32'h8, "t4_ctrl");
      wr(4'h0, A1, 32'h8, "t4_clr");

      // Valid kick on the expiry edge prevents the bite
      wr(4'h0, A1, 32'h1, "t4c_en");
      ticks(10);
      wr(4'h8, A1, 32'hA5, "t4c_kick");
      rd(4'hC, A4, 32'd9, "t4c_cnt");
      ticks(1);
      check_val("t4c_nobite", {31'd0, wdt_rst}, 32'd0);
      rd(4'h0, A1, 32'h1, "t4c_ctrl");
      wr(4'h0, A1, 32'h0, "t4c_dis");

      // LOCK ignores CTRL[2:0]/LOAD writes; watchdog still bites from old LOAD
      wr(4'h0, A1, 32'h5, "t5_en");
      wr(4'h0, A1, 32'h0, "t5_ctrl0");
      wr(4'h4, A4, 32'd5, "t5_load5");
      rd(4'h4, A4, 32'd10, "t5_load");
      rd(4'hC, A4, 32'd6, "t5_cnt");
      rd(4'h0, A1, 32'h5, "t5_ctrl");
      ticks(6);
      check_val("t5_wdt_pre", {31'd0, wdt_rst}, 32'd0);
      ticks(1);
      check_val("t5_wdt", {31'd0, wdt_rst}, 32'd1);
      ticks(4);
      check_val("t5_wdt_fall", {31'd0, wdt_rst}, 32'd0);
      rd(4'h0, A1, 32'hC, "t5_ctrl_after");
      wr(4'h0, A1, 32'h9, "t5_w1c");
      rd(4'h0, A1, 32'h4, "t5_locked");
      rstn = 1'b0;
      ticks(1);
      rstn = 1'b1;
      rd(4'h0, A1, 32'h0, "t5_unlock");

      // Faulted accesses: no response, no side effect, rdata holds
      rd(4'h4, A4, 32'hFFFF_FFFF, "t6_pre");
      fbus(1'b0, 4'h8, A1, 32'h0, "t6_rdkick");
      check_val("t6_rd_hold", rd_s, 32'hFFFF_FFFF);
      fbus(1'b1, 4'h4, A1, 32'h3, "t6_load1b");
      rd(4'h4, A4, 32'hFFFF_FFFF, "t6_load");
      fbus(1'b1, 4'hC, A4, 32'h55, "t6_wrcnt");
      rd(4'hC, A4, 32'h0, "t6_cnt");
      fbus(1'b1, 4'h2, A1, 32'h1, "t6_addr2");
      fbus(1'b1, 4'h0, A4, 32'h1, "t6_ctrl4b");
      rd(4'h0, A1, 32'h0, "t6_ctrl");

      // LOAD=0 expires one cycle after reload
      wr(4'h4, A4, 32'd0, "t7_load");
      wr(4'h0, A1, 32'h1, "t7_en");
      ticks(1);
      check_val("t7_wdt_pre", {31'd0, wdt_rst}, 32'd0);
      ticks(1);
      check_val("t7_wdt", {31'd0, wdt_rst}, 32'd1);
      ticks(3);
      check_val("t7_wdt_hi", {31'd0, wdt_rst}, 32'd1);
      ticks(1);
      check_val("t7_wdt_fall", {31'd0, wdt_rst}, 32'd0);
      wr(4'h0, A1, 32'h8, "t7_clr");

      // Reset in the middle of the pulse truncates it
      wr(4'h4, A4, 32'd2, "t8_load");
      wr(4'h0, A1, 32'h1, "t8_en");
      ticks(4);
      check_val("t8_wdt", {31'd0, wdt_rst}, 32'd1);
      ticks(1);
      check_val("t8_wdt2", {31'd0, wdt_rst}, 32'd1);
      rstn = 1'b0;
      ticks(1);
      check_val("t8_rst_wdt", {31'd0, wdt_rst}, 32'd0);
      check_val("t8_rst_irq", {31'd0, irq}, 32'd0);
      rstn = 1'b1;
      rd(4'h0, A1, 32'h0, "t8_ctrl");
      rd(4'h4, A4, 32'hFFFF_FFFF, "t8_load_rst");
      ticks(6);
      check_val("t8_quiet", {31'd0, wdt_rst}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
